// File: rtl/mc.sv
// Memory controller: serialises one-byte IC/DC requests onto a shared RAM/IO port.
// The DC side has strict priority, and IO-space writes wait while the IO buffer is full.
module mc #(
  parameter int                 ADDR_W  = 32,
  parameter logic [ADDR_W-1:0]  IO_BASE = ADDR_W'(32'h30000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              iIC_En,
  input  logic [ADDR_W-1:0] iIC_Add,
  output logic              oIC_En,
  output logic [7:0]        oIC_Dat,
  input  logic              iDC_En,
  input  logic              iDC_Rw,
  input  logic [ADDR_W-1:0] iDC_Add,
  input  logic [7:0]        iDC_Dat,
  output logic              oDC_En,
  output logic [7:0]        oDC_Dat,
  input  logic [7:0]        iMem_Dat,
  output logic [7:0]        oMem_Dat,
  output logic [ADDR_W-1:0] oMem_Add,
  output logic              oMem_Wr,
  input  logic              iIO_Full
);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, WR_STALL} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_DC} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] add_q, add_d;
  logic [7:0]        mdat_q, mdat_d;
  logic              wr_q, wr_d;
  logic              ic_en_q, ic_en_d;
  logic [7:0]        ic_dat_q, ic_dat_d;
  logic              dc_en_q, dc_en_d;
  logic [7:0]        dc_dat_q, dc_dat_d;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    add_d    = add_q;
    mdat_d   = mdat_q;
    wr_d     = 1'b0;
    ic_en_d  = 1'b0;
    ic_dat_d = ic_dat_q;
    dc_en_d  = 1'b0;
    dc_dat_d = dc_dat_q;
    case (state_q)
      IDLE: begin
        // A request seen while a done pulse is up is the stale one just served.
        if (!ic_en_q && !dc_en_q) begin
          if (iDC_En) begin
            owner_d = OWN_DC;
            add_d   = iDC_Add;
            if (!iDC_Rw) begin
              state_d = RD_ISSUE;
            end else begin
              mdat_d  = iDC_Dat;
              state_d = WR_STALL;
              wr_d    = !((iDC_Add >= IO_BASE) && iIO_Full);
            end
          end else if (iIC_En) begin
            owner_d = OWN_IC;
            add_d   = iIC_Add;
            state_d = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (owner_q == OWN_DC) begin
          dc_en_d  = 1'b1;
          dc_dat_d = iMem_Dat;
        end else begin
          ic_en_d  = 1'b1;
          ic_dat_d = iMem_Dat;
        end
        owner_d = OWN_NONE;
        state_d = IDLE;
      end
      WR_STALL: begin
        // Unstalled writes also pass through here with the strobe already up.
        if (wr_q) begin
          dc_en_d  = 1'b1;
          dc_dat_d = 8'h00;
          owner_d  = OWN_NONE;
          state_d  = IDLE;
        end else if (!iIO_Full) begin
          wr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      add_q    <= '0;
      mdat_q   <= '0;
      wr_q     <= 1'b0;
      ic_en_q  <= 1'b0;
      ic_dat_q <= '0;
      dc_en_q  <= 1'b0;
      dc_dat_q <= '0;
    end else if (en) begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      add_q    <= add_d;
      mdat_q   <= mdat_d;
      wr_q     <= wr_d;
      ic_en_q  <= ic_en_d;
      ic_dat_q <= ic_dat_d;
      dc_en_q  <= dc_en_d;
      dc_dat_q <= dc_dat_d;
    end
  end

  assign oIC_En   = ic_en_q;
  assign oIC_Dat  = ic_dat_q;
  assign oDC_En   = dc_en_q;
  assign oDC_Dat  = dc_dat_q;
  assign oMem_Dat = mdat_q;
  assign oMem_Add = add_q;
  assign oMem_Wr  = wr_q;

endmodule

// File: tb/tb_mc.sv
// Directed bench for mc: a synchronous RAM model plus cycle-exact checks of the
// done pulses, write strobes, priority, IO stall, freeze and reset abort.
module tb_mc;
  logic        clk = 1'b0;
  logic        rst, en;
  logic        iIC_En, iDC_En, iDC_Rw, iIO_Full;
  logic [31:0] iIC_Add, iDC_Add, oMem_Add;
  logic [7:0]  iDC_Dat, oIC_Dat, oDC_Dat, iMem_Dat, oMem_Dat;
  logic        oIC_En, oDC_En, oMem_Wr;

  int checks = 0;
  int failures = 0;
  int ic_done_cnt = 0, dc_done_cnt = 0, wr_cnt = 0, both_seen = 0;
  logic [7:0] mem [0:1023];

  mc dut (
    .clk(clk), .rst(rst), .en(en),
    .iIC_En(iIC_En), .iIC_Add(iIC_Add), .oIC_En(oIC_En), .oIC_Dat(oIC_Dat),
    .iDC_En(iDC_En), .iDC_Rw(iDC_Rw), .iDC_Add(iDC_Add), .iDC_Dat(iDC_Dat),
    .oDC_En(oDC_En), .oDC_Dat(oDC_Dat),
    .iMem_Dat(iMem_Dat), .oMem_Dat(oMem_Dat), .oMem_Add(oMem_Add),
    .oMem_Wr(oMem_Wr), .iIO_Full(iIO_Full)
  );

  always #5 clk = ~clk;

  // RAM: samples address at each edge, data valid the following cycle.
  always @(posedge clk) begin
    iMem_Dat <= mem[oMem_Add[9:0]];
    if (oMem_Wr) mem[oMem_Add[9:0]] <= oMem_Dat;
    if (oMem_Wr) wr_cnt++;
    if (oIC_En) ic_done_cnt++;
    if (oDC_En) dc_done_cnt++;
    if (oIC_En && oDC_En) both_seen++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int w0, n, d0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[16'h10] = 8'hAB;
    for (int i = 0; i < 4; i++) mem[10'h100 + i] = 8'hC0 + 8'(i);
    iMem_Dat = 8'h00;
    rst = 1; en = 1; iIC_En = 0; iDC_En = 0; iDC_Rw = 0; iIO_Full = 0;
    iIC_Add = 0; iDC_Add = 0; iDC_Dat = 0;
    step(2);
    check("rst_ic_en", oIC_En, 0);
    check("rst_dc_en", oDC_En, 0);
    check("rst_wr", oMem_Wr, 0);
    check("rst_add", oMem_Add, 0);
    check("rst_mdat", oMem_Dat, 0);
    rst = 0;
    step(1);

    // IC read 0x10
    iIC_En = 1; iIC_Add = 32'h10;
    step(1);
    check("t1_add", oMem_Add, 32'h10);
    check("t1_en_e0", oIC_En, 0);
    step(1);
    check("t1_en_e1", oIC_En, 0);
    step(1);
    check("t1_done", oIC_En, 1);
    check("t1_dat", oIC_Dat, 8'hAB);
    iIC_En = 0;
    step(1);
    check("t1_pulse_end", oIC_En, 0);

    // DC write then read back (request held straight through the cooldown)
    w0 = wr_cnt;
    iDC_En = 1; iDC_Rw = 1; iDC_Add = 32'h20; iDC_Dat = 8'h5C;
    step(1);
    check("t2_wr", oMem_Wr, 1);
    check("t2_wr_add", oMem_Add, 32'h20);
    check("t2_wr_dat", oMem_Dat, 8'h5C);
    check("t2_no_done_yet", oDC_En, 0);
    step(1);
    check("t2_wr_off", oMem_Wr, 0);
    check("t2_done", oDC_En, 1);
    check("t2_done_dat0", oDC_Dat, 0);
    check("t2_wr_count", wr_cnt - w0, 1);
    iDC_Rw = 0;
    step(1);
    check("t2_cooldown", oDC_En, 0);
    step(2);
    check("t2_rd_not_yet", oDC_En, 0);
    step(1);
    check("t2_rd_done", oDC_En, 1);
    check("t2_rd_dat", oDC_Dat, 8'h5C);
    iDC_En = 0;
    step(1);

    // Simultaneous requests: DC first
    iIC_En = 1; iIC_Add = 32'h10;
    iDC_En = 1; iDC_Rw = 0; iDC_Add = 32'h20;
    step(3);
    check("t3_dc_done", oDC_En, 1);
    check("t3_dc_dat", oDC_Dat, 8'h5C);
    check("t3_ic_wait", oIC_En, 0);
    iDC_En = 0;
    step(1);
    check("t3_cool_ic", oIC_En, 0);
    check("t3_cool_dc", oDC_En, 0);
    step(2);
    check("t3_ic_not_yet", oIC_En, 0);
    step(1);
    check("t3_ic_done", oIC_En, 1);
    check("t3_ic_dat", oIC_Dat, 8'hAB);
    iIC_En = 0;
    n = ic_done_cnt; d0 = dc_done_cnt;
    step(6);
    check("t3_no_dup_ic", ic_done_cnt - n, 1);
    check("t3_no_dup_dc", dc_done_cnt - d0, 0);

    // IO write stalled 5 cycles
    w0 = wr_cnt;
    iIO_Full = 1; iDC_En = 1; iDC_Rw = 1; iDC_Add = 32'h30000; iDC_Dat = 8'h77;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("t4_stall_wr", oMem_Wr, 0);
      check("t4_stall_done", oDC_En, 0);
    end
    iIO_Full = 0;
    step(1);
    check("t4_strobe", oMem_Wr, 1);
    check("t4_add", oMem_Add, 32'h30000);
    check("t4_dat", oMem_Dat, 8'h77);
    step(1);
    check("t4_strobe_off", oMem_Wr, 0);
    check("t4_done", oDC_En, 1);
    check("t4_wr_count", wr_cnt - w0, 1);
    iDC_En = 0;
    step(2);

    // DC streaming reads 0x100..0x103
    d0 = dc_done_cnt;
    iDC_En = 1; iDC_Rw = 0; iDC_Add = 32'h100;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin
        step(1);
        n++;
      end while (!oDC_En && n < 12);
      check("t5_latency", n, (i == 0) ? 3 : 4);
      check("t5_dat", oDC_Dat, 8'hC0 + 8'(i));
      check("t5_add", oMem_Add, 32'h100 + i);
      if (i < 3) iDC_Add = 32'h101 + i;
      else iDC_En = 0;
    end
    step(6);
    check("t5_count", dc_done_cnt - d0, 4);

    // en=0 freeze during RD_WAIT
    iIC_En = 1; iIC_Add = 32'h10;
    step(2);
    en = 0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("t6_frozen_en", oIC_En, 0);
      check("t6_frozen_add", oMem_Add, 32'h10);
    end
    en = 1;
    step(1);
    check("t6_resume_done", oIC_En, 1);
    check("t6_resume_dat", oIC_Dat, 8'hAB);
    iIC_En = 0;
    step(2);

    // reset during RD_WAIT
    d0 = dc_done_cnt;
    iDC_En = 1; iDC_Rw = 0; iDC_Add = 32'h20;
    step(2);
    rst = 1;
    step(1);
    check("t6_rst_dc_en", oDC_En, 0);
    check("t6_rst_add", oMem_Add, 0);
    check("t6_rst_wr", oMem_Wr, 0);
    check("t6_rst_icdat", oIC_Dat, 0);
    check("t6_rst_dcdat", oDC_Dat, 0);
    iDC_En = 0; rst = 0;
    step(4);
    check("t6_rst_no_done", dc_done_cnt - d0, 0);
    check("never_both_done", both_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
